branch_resolver: RTL and testbench

- Initiator side of the C_ALU comparator interface. Accepts conditional-branch requests over a valid/ready handshake and drives the comparator's op/in0/in1.
- Samples the comparator's 1-bit result, then returns the taken flag and the next PC over a second valid/ready handshake.
- Sits between decode and PC update in the Unicycle datapath.

---
 rtl/branch_resolver.sv | 121 ++++++++++++
 tb/tb_branch_resolver.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolver.sv
// Conditional-branch resolver: drives the C_ALU comparator, waits CMP_WAIT cycles,
// then returns taken/next-PC. Define BRANCH_RESOLVER_STATS_EN for delivery counters.
module branch_resolver #(
    parameter int WIDTH    = 16,
    parameter int CMP_WAIT = 1,
    parameter int PC_STEP  = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [WIDTH-1:0] req_pc,
    input  logic [WIDTH-1:0] req_offset,
    output logic [1:0]       cmp_op,
    output logic [WIDTH-1:0] cmp_in0,
    output logic [WIDTH-1:0] cmp_in1,
    input  logic             cmp_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_taken,
    output logic [WIDTH-1:0] res_next_pc
`ifdef BRANCH_RESOLVER_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_total,
    output logic [CNT_W-1:0] stat_taken
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic [3:0]       wait_cnt;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] offset_q;
    logic [WIDTH-1:0] fall_through;
    logic [WIDTH-1:0] target;

    // NOTE: req_ready is a continuous assign on state and flush only, so no latch
    // and no path from req_valid back into the handshake.
    assign req_ready    = (state == IDLE) && !flush;
    assign fall_through = pc_q + WIDTH'(PC_STEP);
    assign target       = fall_through + offset_q;

    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            pc_q        <= '0;
            offset_q    <= '0;
            cmp_op      <= 2'b00;
            cmp_in0     <= '0;
            cmp_in1     <= '0;
            res_valid   <= 1'b0;
            res_taken   <= 1'b0;
            res_next_pc <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        cmp_op   <= req_op;
                        cmp_in0  <= req_a;
                        cmp_in1  <= req_b;
                        pc_q     <= req_pc;
                        offset_q <= req_offset;
                        wait_cnt <= 4'(CMP_WAIT - 1);
                        state    <= CMP;
                    end
                end
                CMP: begin
                    if (flush) begin
                        wait_cnt <= '0;
                        state    <= IDLE;
                    end else if (wait_cnt == 4'd0) begin
                        res_taken   <= cmp_out;
                        res_next_pc <= cmp_out ? target : fall_through;
                        res_valid   <= 1'b1;
                        state       <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                RESP: begin
                    // A flush coinciding with res_ready discards the result.
                    if (flush) begin
                        res_valid <= 1'b0;
                        wait_cnt  <= '0;
                        state     <= IDLE;
                    end else if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BRANCH_RESOLVER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_total <= '0;
            stat_taken <= '0;
        end else if (state == RESP && res_valid && res_ready && !flush) begin
            stat_total <= stat_total + 1'b1;
            if (res_taken) stat_taken <= stat_taken + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: a transaction-level model sets the expected
// outputs per cycle and one negedge process compares them against the DUT.
module tb_branch_resolver;

    localparam int W        = 16;
    localparam int CMP_WAIT = 1;
    localparam int M_NORM       = 0;
    localparam int M_FLUSH_CMP  = 1;
    localparam int M_FLUSH_RESP = 2;
    localparam int M_RESET      = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, flush, req_valid, req_ready, res_valid, res_ready, res_taken, cmp_out;
    logic [1:0]   req_op, cmp_op;
    logic [W-1:0] req_a, req_b, req_pc, req_offset, cmp_in0, cmp_in1, res_next_pc;
`ifdef BRANCH_RESOLVER_STATS_EN
    logic [15:0]  stat_total, stat_taken;
`endif

    // Second instance with a longer comparator wait, driven independently.
    logic         flush3, req_valid3, req_ready3, res_valid3, res_ready3, res_taken3, cmp_out3;
    logic [1:0]   req_op3, cmp_op3;
    logic [W-1:0] req_a3, req_b3, req_pc3, req_offset3, cmp_in03, cmp_in13, res_next_pc3;
`ifdef BRANCH_RESOLVER_STATS_EN
    logic [15:0]  stat_total3, stat_taken3;
`endif

    int total = 0;
    int bad   = 0;

    logic         chk_en = 1'b0;
    logic         exp_ready, exp_valid, exp_taken;
    logic [W-1:0] exp_pc, exp_in0, exp_in1;
    logic [1:0]   exp_op;
    int           exp_total = 0;
    int           exp_taken_n = 0;

    function automatic logic cmp_model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            2'b00:   return a == b;
            2'b01:   return a < b;
            2'b10:   return a != b;
            default: return a >= b;
        endcase
    endfunction

    function automatic logic [W-1:0] next_pc_model(input logic t, input logic [W-1:0] pc, input logic [W-1:0] off);
        logic [W-1:0] r;
        r = pc + 16'd1;
        if (t) r = r + off;
        return r;
    endfunction

    assign cmp_out  = cmp_model(cmp_op, cmp_in0, cmp_in1);
    assign cmp_out3 = cmp_model(cmp_op3, cmp_in03, cmp_in13);

    branch_resolver #(.WIDTH(W), .CMP_WAIT(CMP_WAIT), .PC_STEP(1), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_pc(req_pc), .req_offset(req_offset),
        .cmp_op(cmp_op), .cmp_in0(cmp_in0), .cmp_in1(cmp_in1), .cmp_out(cmp_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_taken(res_taken),
        .res_next_pc(res_next_pc)
`ifdef BRANCH_RESOLVER_STATS_EN
        , .stat_total(stat_total), .stat_taken(stat_taken)
`endif
    );

    branch_resolver #(.WIDTH(W), .CMP_WAIT(3), .PC_STEP(1), .CNT_W(16)) dut3 (
        .clk(clk), .rst(rst), .flush(flush3),
        .req_valid(req_valid3), .req_ready(req_ready3), .req_op(req_op3),
        .req_a(req_a3), .req_b(req_b3), .req_pc(req_pc3), .req_offset(req_offset3),
        .cmp_op(cmp_op3), .cmp_in0(cmp_in03), .cmp_in1(cmp_in13), .cmp_out(cmp_out3),
        .res_valid(res_valid3), .res_ready(res_ready3), .res_taken(res_taken3),
        .res_next_pc(res_next_pc3)
`ifdef BRANCH_RESOLVER_STATS_EN
        , .stat_total(stat_total3), .stat_taken(stat_taken3)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("req_ready",   32'(req_ready),   32'(exp_ready));
            check("res_valid",   32'(res_valid),   32'(exp_valid));
            check("res_taken",   32'(res_taken),   32'(exp_taken));
            check("res_next_pc", 32'(res_next_pc), 32'(exp_pc));
            check("cmp_op",      32'(cmp_op),      32'(exp_op));
            check("cmp_in0",     32'(cmp_in0),     32'(exp_in0));
            check("cmp_in1",     32'(cmp_in1),     32'(exp_in1));
`ifdef BRANCH_RESOLVER_STATS_EN
            check("stat_total",  32'(stat_total),  32'(exp_total[15:0]));
            check("stat_taken",  32'(stat_taken),  32'(exp_taken_n[15:0]));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        exp_ready   = 1'b1;
        exp_valid   = 1'b0;
        exp_taken   = 1'b0;
        exp_pc      = '0;
        exp_op      = 2'b00;
        exp_in0     = '0;
        exp_in1     = '0;
        exp_total   = 0;
        exp_taken_n = 0;
    endtask

    // One branch from IDLE; mode selects delivery, flush in CMP/RESP, or reset in RESP.
    task automatic run_branch(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] pc, input logic [W-1:0] off, input int hold,
                              input int mode, input logic lit_t, input logic [W-1:0] lit_pc);
        logic         t;
        logic [W-1:0] np;
        t  = cmp_model(op, a, b);
        np = next_pc_model(t, pc, off);
        check("model_taken", 32'(t),  32'(lit_t));
        check("model_pc",    32'(np), 32'(lit_pc));

        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_pc = pc; req_offset = off;
        exp_ready = 1'b1;
        tick();
        // Request stays asserted with junk payload: it must be ignored outside IDLE.
        req_op = ~op; req_a = ~a; req_b = ~b; req_pc = ~pc; req_offset = ~off;
        exp_ready = 1'b0; exp_op = op; exp_in0 = a; exp_in1 = b;
        if (mode == M_FLUSH_CMP) begin
            flush = 1'b1; req_valid = 1'b0;
            tick();
            flush = 1'b0; exp_ready = 1'b1;
            return;
        end
        repeat (CMP_WAIT) tick();
        req_valid = 1'b0;
        exp_valid = 1'b1; exp_taken = t; exp_pc = np;
        if (mode == M_FLUSH_RESP) begin
            res_ready = 1'b1; flush = 1'b1;
            tick();
            res_ready = 1'b0; flush = 1'b0;
            exp_valid = 1'b0; exp_ready = 1'b1;
        end else if (mode == M_RESET) begin
            res_ready = 1'b0;
            tick();
            rst = 1'b1;
            tick();
            rst = 1'b0;
            model_reset();
        end else begin
            res_ready = 1'b0;
            repeat (hold) tick();
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
            exp_valid = 1'b0; exp_ready = 1'b1;
            exp_total++;
            if (t) exp_taken_n++;
        end
    endtask

    task automatic flush_idle();
        req_valid = 1'b1; flush = 1'b1;
        req_op = 2'b11; req_a = 16'hDEAD; req_b = 16'hBEEF; req_pc = 16'h0BAD; req_offset = 16'h0001;
        exp_ready = 1'b0;
        tick();
        req_valid = 1'b0; flush = 1'b0;
        exp_ready = 1'b1;
    endtask

    task automatic run_wait3();
        int n;
        check("wait3_ready", 32'(req_ready3), 32'd1);
        req_valid3 = 1'b1; req_op3 = 2'b01; req_a3 = 16'h0001; req_b3 = 16'h0002;
        req_pc3 = 16'h0040; req_offset3 = 16'h0008;
        n = 0;
        do begin
            tick();
            req_valid3 = 1'b0;
            n++;
        end while (!res_valid3 && n < 20);
        check("wait3_latency", 32'(n), 32'd4);
        check("wait3_taken",   32'(res_taken3), 32'd1);
        check("wait3_next_pc", 32'(res_next_pc3), 32'h0049);
        res_ready3 = 1'b1;
        tick();
        res_ready3 = 1'b0;
        check("wait3_valid_clr", 32'(res_valid3), 32'd0);
        check("wait3_ready_ret", 32'(req_ready3), 32'd1);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; req_valid = 1'b0; res_ready = 1'b0;
        req_op = '0; req_a = '0; req_b = '0; req_pc = '0; req_offset = '0;
        flush3 = 1'b0; req_valid3 = 1'b0; res_ready3 = 1'b0;
        req_op3 = '0; req_a3 = '0; req_b3 = '0; req_pc3 = '0; req_offset3 = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        chk_en = 1'b1;

        run_branch(2'b00, 16'h0001, 16'h0003, 16'h0010, 16'h0004, 0, M_NORM, 1'b0, 16'h0011);
        run_branch(2'b01, 16'h0001, 16'hFFFC, 16'h0010, 16'h0004, 0, M_NORM, 1'b1, 16'h0015);
        run_branch(2'b01, 16'hFFFF, 16'hFFF0, 16'h0010, 16'h0004, 0, M_NORM, 1'b0, 16'h0011);
        run_branch(2'b11, 16'hFFFF, 16'hFFF0, 16'h0020, 16'hFFF0, 0, M_NORM, 1'b1, 16'h0011);
        run_branch(2'b10, 16'h1234, 16'h1234, 16'h0020, 16'hFFF0, 0, M_NORM, 1'b0, 16'h0021);
        run_branch(2'b10, 16'h0001, 16'h0002, 16'hFFFF, 16'h0001, 5, M_NORM, 1'b1, 16'h0001);
        run_branch(2'b00, 16'h0001, 16'h0002, 16'hFFFF, 16'h0001, 0, M_NORM, 1'b0, 16'h0000);
        run_branch(2'b00, 16'h0005, 16'h0005, 16'h0100, 16'hFFFE, 0, M_NORM, 1'b1, 16'h00FF);
        flush_idle();
        run_branch(2'b00, 16'h0007, 16'h0007, 16'h0030, 16'h0002, 0, M_FLUSH_CMP,  1'b1, 16'h0033);
        run_branch(2'b01, 16'h0002, 16'h0003, 16'h0050, 16'h0010, 0, M_FLUSH_RESP, 1'b1, 16'h0061);
        run_branch(2'b11, 16'h0002, 16'h0003, 16'h0060, 16'h0004, 2, M_NORM, 1'b0, 16'h0061);
        tick();
        run_branch(2'b11, 16'h0003, 16'h0003, 16'h0070, 16'h0000, 0, M_RESET, 1'b1, 16'h0071);
        run_branch(2'b10, 16'h0000, 16'h0001, 16'h0080, 16'h0100, 0, M_NORM, 1'b1, 16'h0181);
        tick();
        run_wait3();
        tick();

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
